mdu_sequencer: RTL and testbench
================================

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 SHALL have: clock  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have: start  input  1  request new operation; sampled only in IDLE.
REQ-004 SHALL have: op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have: operand_a  input  32  multiplicand / dividend.
REQ-006 SHALL have: operand_b  input  32  multiplier / divisor.
REQ-007 SHALL have: flush  input  1  synchronous abort from pipeline.
REQ-008 SHALL have: busy  output  1  high in every state except IDLE; drives pipeline stall.
REQ-009 SHALL have: hilo_write_enable  output  1  one-cycle pulse; drives HI/LO register write enable.
REQ-010 SHALL have: hi_result  output  32  HI data (product[63:32] or remainder).
REQ-011 SHALL have: lo_result  output  32  LO data (product[31:0] or quotient).
REQ-012 SHALL have: div_by_zero  output  1  one-cycle pulse on DIV/DIVU with operand_b == 0.

Function
REQ-013 SHALL implement FSM states IDLE, PREP, CALC, FIX, WRITE.
REQ-014 IDLE: start=1 and flush=0 -> latch op, operand_a, operand_b; go PREP. Otherwise stay.
REQ-015 PREP (1 cycle): signed ops -> latch absolute values and result signs; unsigned -> operands as-is; clear 64-bit accumulator, 6-bit iteration counter = 0; go CALC.
REQ-016 PREP, DIV/DIVU with divisor 0 -> assert div_by_zero this cycle, go IDLE; no write, hi_result/lo_result unchanged.
REQ-017 CALC: exactly 32 cycles, one bit per cycle; multiply = shift-add into 64-bit accumulator, divide = restoring shift-subtract (32-bit quotient, 32-bit remainder); after iteration 31 go FIX.
REQ-018 FIX (1 cycle): negate product if sign(a) XOR sign(b) for MULT; for DIV negate quotient if sign(a) XOR sign(b), negate remainder if sign(a); register results into hi_result/lo_result; go WRITE.
REQ-019 WRITE (1 cycle): hilo_write_enable=1; go IDLE.
REQ-020 Latency: start sampled at edge k -> hilo_write_enable high in cycle after edge k+34; busy low again after edge k+35. Fixed, data-independent.
REQ-021 start while busy=1 (including WRITE cycle) SHALL be ignored; no queuing.
REQ-022 flush=1 in PREP, CALC or FIX -> IDLE at next edge; no write, results unchanged; div_by_zero suppressed. flush in WRITE does not cancel the write.
REQ-023 flush and start together in IDLE -> start ignored.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0x00000000 (wraps, no exception).
REQ-025 hi_result/lo_result SHALL hold last written values between operations; change only in FIX.
REQ-026 Operand inputs SHALL be don't-care after the acceptance edge.

Reset
REQ-027 reset SHALL force IDLE; busy=0, hilo_write_enable=0, div_by_zero=0, hi_result=0, lo_result=0, counter=0, accumulator=0.
REQ-028 reset mid-operation SHALL abandon it with no write pulse; first start after reset release accepted normally.

Verification
REQ-029 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> single hilo_write_enable at k+35 cycle, HI=0xFFFFFFFE, LO=0x00000001, busy 35 cycles.
REQ-030 MULT 0xFFFFFFFD (-3) x 0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-031 DIV 0xFFFFFFF9 (-7) / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2.
REQ-032 DIVU 100 / 0 -> div_by_zero one cycle after acceptance, no hilo_write_enable, HI/LO keep prior values, busy low after 2 cycles.
REQ-033 flush in CALC cycle 10 -> busy low next cycle, no write pulse; back-to-back start then accepted and completes correctly.
REQ-034 start pulsed during busy and during WRITE -> ignored; assert reset in CALC -> all outputs 0 immediately, no write pulse.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with fixed 35-cycle latency.
// One product/quotient bit per cycle; signs are stripped up front and restored in FIX.
module mdu_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        flush,
  output logic        busy,
  output logic        hilo_write_enable,
  output logic [31:0] hi_result,
  output logic [31:0] lo_result,
  output logic        div_by_zero
);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    WRITE
  } state_t;

  state_t      state;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [63:0] acc;
  logic [5:0]  cnt;
  logic        neg_p;
  logic        neg_r;

  logic        is_div;
  logic        is_signed;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [63:0] acc_mul;
  logic [32:0] trial;
  logic        qbit;
  logic [31:0] rem_next;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];

  assign a_abs = (is_signed && a_q[31]) ? -a_q : a_q;
  assign b_abs = (is_signed && b_q[31]) ? -b_q : b_q;

  assign acc_mul = {acc[62:0], 1'b0}
                 + (b_q[31] ? {32'd0, a_q} : 64'd0);

  // Restoring step: remainder invariant keeps the 33-bit trial from overflowing
  assign trial    = {acc[63:32], a_q[31]} - {1'b0, b_q};
  assign qbit     = ~trial[32];
  assign rem_next = qbit ? trial[31:0] : {acc[62:32], a_q[31]};

  assign prod_fix = neg_p ? -acc : acc;
  assign quo_fix  = neg_p ? -acc[31:0] : acc[31:0];
  assign rem_fix  = neg_r ? -acc[63:32] : acc[63:32];

  assign div_by_zero = (state == PREP) & is_div
                     & (b_q == 32'd0) & ~flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      op_q              <= 2'd0;
      a_q               <= 32'd0;
      b_q               <= 32'd0;
      acc               <= 64'd0;
      cnt               <= 6'd0;
      neg_p             <= 1'b0;
      neg_r             <= 1'b0;
      busy              <= 1'b0;
      hilo_write_enable <= 1'b0;
      hi_result         <= 32'd0;
      lo_result         <= 32'd0;
    end else begin
      hilo_write_enable <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !flush) begin
            op_q  <= op;
            a_q   <= operand_a;
            b_q   <= operand_b;
            busy  <= 1'b1;
            state <= PREP;
          end
        end
        PREP: begin
          if (flush || (is_div && b_q == 32'd0)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            a_q   <= a_abs;
            b_q   <= b_abs;
            neg_p <= is_signed & (a_q[31] ^ b_q[31]);
            neg_r <= is_signed & a_q[31];
            acc   <= 64'd0;
            cnt   <= 6'd0;
            state <= CALC;
          end
        end
        CALC: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (is_div) begin
              acc <= {rem_next, acc[30:0], qbit};
              a_q <= {a_q[30:0], 1'b0};
            end else begin
              acc <= acc_mul;
              b_q <= {b_q[30:0], 1'b0};
            end
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31)
              state <= FIX;
          end
        end
        FIX: begin
          if (flush) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            if (is_div) begin
              hi_result <= rem_fix;
              lo_result <= quo_fix;
            end else begin
              hi_result <= prod_fix[63:32];
              lo_result <= prod_fix[31:0];
            end
            hilo_write_enable <= 1'b1;
            state             <= WRITE;
          end
        end
        WRITE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: latency, arithmetic corners,
// divide-by-zero, flush, ignored starts and mid-operation reset.
module tb_mdu_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        busy;
  logic        hilo_write_enable;
  logic [31:0] hi_result;
  logic [31:0] lo_result;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;
  int we_count = 0;
  int snap;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  mdu_sequencer dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .op                (op),
    .operand_a         (operand_a),
    .operand_b         (operand_b),
    .flush             (flush),
    .busy              (busy),
    .hilo_write_enable (hilo_write_enable),
    .hi_result         (hi_result),
    .lo_result         (lo_result),
    .div_by_zero       (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock)
    if (hilo_write_enable === 1'b1)
      we_count++;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Leaves the caller at the falling edge just after the acceptance edge
  task automatic issue(input logic [1:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clock);
    start = 1'b1;
    op = o;
    operand_a = a;
    operand_b = b;
    @(negedge clock);
    start = 1'b0;
    op = 2'($urandom);
    operand_a = $urandom;
    operand_b = $urandom;
  endtask

  task automatic run(input string tag,
                     input logic [31:0] ehi,
                     input logic [31:0] elo,
                     input bit poke);
    int pulses = 0;
    int we_at = 0;
    int busy_bad = 0;
    for (int c = 1; c <= 36; c++) begin
      if (c > 1) @(negedge clock);
      if (hilo_write_enable === 1'b1) begin
        pulses++;
        we_at = c;
      end
      if (busy !== (c <= 35)) busy_bad++;
      if (poke) begin
        if (c == 5 || c == 35) begin
          start = 1'b1;
          op = DIVU;
          operand_a = 32'd50;
          operand_b = 32'd5;
        end
        if (c == 6 || c == 36) start = 1'b0;
      end
    end
    check({tag, "_pulses"}, 64'(pulses), 64'd1);
    check({tag, "_we_at"}, 64'(we_at), 64'd35);
    check({tag, "_busy"}, 64'(busy_bad), 64'd0);
    check({tag, "_hi"}, {32'd0, hi_result}, {32'd0, ehi});
    check({tag, "_lo"}, {32'd0, lo_result}, {32'd0, elo});
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op = 2'd0;
    operand_a = 32'd0;
    operand_b = 32'd0;
    flush = 1'b0;

    #12;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_we", {63'd0, hilo_write_enable}, 64'd0);
    check("rst_dz", {63'd0, div_by_zero}, 64'd0);
    check("rst_hilo", {hi_result, lo_result}, 64'd0);
    @(negedge clock);
    reset = 1'b0;

    issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run("multu_max", 32'hFFFFFFFE, 32'h00000001, 1'b0);

    issue(MULT, 32'hFFFFFFFD, 32'h00000007);
    run("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);

    issue(MULT, 32'h80000000, 32'h00000002);
    run("mult_min", 32'hFFFFFFFF, 32'h00000000, 1'b0);

    issue(DIV, 32'hFFFFFFF9, 32'h00000002);
    run("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);

    issue(DIVU, 32'd100, 32'd7);
    run("divu", 32'd2, 32'd14, 1'b0);

    issue(DIV, 32'h80000000, 32'hFFFFFFFF);
    run("div_wrap", 32'h00000000, 32'h80000000, 1'b0);

    // Divide by zero: flag in PREP, then straight back to IDLE
    snap = we_count;
    issue(DIVU, 32'd100, 32'd0);
    check("dz_flag", {63'd0, div_by_zero}, 64'd1);
    check("dz_busy1", {63'd0, busy}, 64'd1);
    @(negedge clock);
    check("dz_flag_off", {63'd0, div_by_zero}, 64'd0);
    check("dz_busy2", {63'd0, busy}, 64'd0);
    repeat (3) @(negedge clock);
    check("dz_nowrite", 64'(we_count - snap), 64'd0);
    check("dz_hilo", {hi_result, lo_result}, 64'h00000000_80000000);

    // Flush in CALC cycle 10, then immediate restart
    snap = we_count;
    issue(MULTU, 32'd5, 32'd6);
    repeat (10) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("fl_busy", {63'd0, busy}, 64'd0);
    check("fl_nowrite", 64'(we_count - snap), 64'd0);
    check("fl_hilo", {hi_result, lo_result}, 64'h00000000_80000000);
    issue(DIVU, 32'd1000, 32'd3);
    run("fl_restart", 32'd1, 32'd333, 1'b0);

    // Starts while busy and in WRITE are dropped
    snap = we_count;
    issue(MULTU, 32'd3, 32'd4);
    run("ignore", 32'd0, 32'd12, 1'b1);
    @(negedge clock);
    check("ignore_idle", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clock);
    check("ignore_one_wr", 64'(we_count - snap), 64'd1);
    check("ignore_hilo", {hi_result, lo_result}, 64'd12);

    // Flush in PREP masks the divide-by-zero flag
    issue(DIVU, 32'd5, 32'd0);
    flush = 1'b1;
    #1;
    check("flprep_dz", {63'd0, div_by_zero}, 64'd0);
    @(negedge clock);
    flush = 1'b0;
    check("flprep_busy", {63'd0, busy}, 64'd0);

    // Reset during CALC
    snap = we_count;
    issue(MULTU, 32'h00010000, 32'h00030000);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    #1;
    check("rstc_busy", {63'd0, busy}, 64'd0);
    check("rstc_we", {63'd0, hilo_write_enable}, 64'd0);
    check("rstc_dz", {63'd0, div_by_zero}, 64'd0);
    check("rstc_hilo", {hi_result, lo_result}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("rstc_nowrite", 64'(we_count - snap), 64'd0);
    issue(MULTU, 32'h00010000, 32'h00030000);
    run("after_rst", 32'd3, 32'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
